weighted_center_of_mass: RTL and testbench
==========================================

// Module: weighted_center_of_mass
// PURPOSE
//  Computes the mass-weighted centre of mass of NUM_NODES soft-body nodes in DIMS axes.
//  It generalises the unit-mass COM: per-node mass, parametrised axis count and signed positions.
//  It has its own shared-control sequential divider, zero-mass detection and a busy/valid handshake.
//  It sits between the physics node-state registers and the camera/render and collision logic.
// PARAMETERS
//  POSITION_SIZE  11  signed bits per position coordinate and per COM output coordinate
//  MASS_SIZE      8   unsigned bits per node mass
//  NUM_NODES      16  nodes per body (>=2)
//  DIMS           2   axes; index 0 = x, 1 = y, ...
//  ACC_W (localparam) = POSITION_SIZE+MASS_SIZE+$clog2(NUM_NODES); sum and divider width
// PORTS
//  clk_in          in   1                              system clock; all logic on posedge
//  rst_in          in   1                              synchronous, active-high reset
//  valid_in        in   1                              request; accepted only when busy_out==0
//  nodes_in        in   DIMS*NUM_NODES*POSITION_SIZE   signed positions; node n, axis d at slice (d*NUM_NODES+n)*POSITION_SIZE
//  masses_in       in   NUM_NODES*MASS_SIZE            unsigned masses; node n at slice n*MASS_SIZE
//  com_out         out  DIMS*POSITION_SIZE             signed COM; axis d at slice d*POSITION_SIZE
//  mass_total_out  out  MASS_SIZE+$clog2(NUM_NODES)    sum of masses for the last result
//  valid_out       out  1                              one-cycle pulse: result registers updated
//  error_out       out  1                              pulse with valid_out when total mass == 0
//  busy_out        out  1                              high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. com_out, mass_total_out, valid_out, error_out, busy_out, sums, counters = 0.
//    A reset mid-operation aborts the operation. It produces no valid_out.
//  - FSM: IDLE -> TALLY -> DIVIDE -> DONE -> IDLE. ZERO_MASS skips DIVIDE.
//  - IDLE: valid_in=1 at edge k snapshots nodes_in/masses_in into internal registers.
//    It clears the sums and node counter and enters TALLY. Inputs may change after edge k.
//  - TALLY: one node per cycle, node 0 first, for NUM_NODES cycles.
//    Per axis: sum_d += signed(pos_d,n) * unsigned(mass_n). Also mass_sum += mass_n.
//    Sums are sign-extended to ACC_W. Overflow is impossible by sizing.
//  - After the last node: if mass_sum==0, go to DONE with error flagged. Otherwise go to DIVIDE.
//  - DIVIDE: restoring divider, one quotient bit per cycle, all axes in parallel, ACC_W cycles.
//    Division is |sum_d| / mass_sum. Negate the quotient if sum_d<0, so it truncates toward zero.
//    The remainder is discarded.
//  - The quotient always lies within [min pos, max pos] for the axis.
//    Truncate it to POSITION_SIZE with no saturation.
//  - DONE (1 cycle): com_out and mass_total_out are registered and valid_out=1.
//    error_out=1 for a zero-mass result. In that case com_out=0 and mass_total_out=0.
//    Next cycle: IDLE, valid_out=0, error_out=0. Outputs hold until the next DONE.
//  - Latency: valid_out is high in cycle k+NUM_NODES+ACC_W+1 (default k+40).
//    For a zero-mass result it is high in cycle k+NUM_NODES+1.
//  - valid_in while busy_out=1, including in DONE, is ignored and not queued.
//    The earliest next accept is the cycle after valid_out.
//  - Nodes with mass 0 contribute nothing. A single non-zero mass returns that node's position exactly.
// TESTING
//  1. Unit masses, x_n=n (0..15), y_n=-5 for all n -> com x=7 (120/16 truncated), y=-5.
//     mass_total_out=16, valid_out at k+40.
//  2. Node0 x=-10 m=3, node1 x=4 m=1, others m=0 -> x = -26/4 = -6 (toward zero), mass_total_out=4.
//  3. All masses 0 -> valid_out and error_out pulse at k+17, com_out=0, mass_total_out=0.
//     Next request then succeeds normally.
//  4. Change inputs and pulse valid_in during TALLY/DIVIDE/DONE -> result uses the snapshot from k.
//     Exactly one valid_out; busy_out stays high throughout.
//  5. Assert rst_in at TALLY cycle 5 -> all outputs 0 next cycle, no valid_out.
//     A fresh request then gives the correct case-1 result.
//  6. Extremes: all x=-1024 with m=255 -> x=-1024; all x=1023 -> x=1023. No overflow or wrap.

Source files
------------

// File: rtl/weighted_center_of_mass.sv
// rtl/weighted_center_of_mass.sv - mass-weighted centre of mass over NUM_NODES nodes in DIMS axes
//
// Purpose: snapshots node positions and masses, accumulates sum(pos*mass) per axis and
// sum(mass) one node per cycle, then runs a shared-control restoring divider (one quotient
// bit per cycle, all axes in parallel) to produce the signed centre of mass.
//
// Ports:
//   clk_in          system clock, all logic on posedge
//   rst_in          synchronous active-high reset
//   valid_in        request, accepted only while busy_out==0
//   nodes_in        signed positions, node n axis d at slice (d*NUM_NODES+n)*POSITION_SIZE
//   masses_in       unsigned masses, node n at slice n*MASS_SIZE
//   com_out         signed COM, axis d at slice d*POSITION_SIZE
//   mass_total_out  total mass of the last result
//   valid_out       one-cycle pulse when result registers update
//   error_out       pulses with valid_out when the total mass is zero
//   busy_out        high in every state except IDLE
module weighted_center_of_mass #(
  parameter int POSITION_SIZE = 11,
  parameter int MASS_SIZE     = 8,
  parameter int NUM_NODES     = 16,
  parameter int DIMS          = 2
) (
  input  logic                                        clk_in,
  input  logic                                        rst_in,
  input  logic                                        valid_in,
  input  logic [DIMS*NUM_NODES*POSITION_SIZE-1:0]     nodes_in,
  input  logic [NUM_NODES*MASS_SIZE-1:0]              masses_in,
  output logic [DIMS*POSITION_SIZE-1:0]               com_out,
  output logic [MASS_SIZE+$clog2(NUM_NODES)-1:0]      mass_total_out,
  output logic                                        valid_out,
  output logic                                        error_out,
  output logic                                        busy_out
);

  localparam int NW    = $clog2(NUM_NODES);
  localparam int ACC_W = POSITION_SIZE + MASS_SIZE + NW;
  localparam int MW    = MASS_SIZE + NW;
  localparam int PW    = POSITION_SIZE + MASS_SIZE + 1;
  localparam int CW    = NW + 1;
  localparam int BW    = $clog2(ACC_W);

  typedef enum logic [1:0] {S_IDLE, S_TALLY, S_DIVIDE, S_DONE} state_t;

  state_t                          state_q;
  logic signed [POSITION_SIZE-1:0] pos_q  [DIMS][NUM_NODES];
  logic        [MASS_SIZE-1:0]     mass_q [NUM_NODES];
  logic        [CW-1:0]            cnt_q;
  logic        [BW-1:0]            bit_q;
  logic signed [ACC_W-1:0]         sum_q  [DIMS];
  logic        [MW-1:0]            mass_sum_q;
  logic        [ACC_W-1:0]         rem_q  [DIMS];
  logic        [ACC_W-1:0]         quo_q  [DIMS];
  logic        [DIMS-1:0]          neg_q;

  logic [DIMS*POSITION_SIZE-1:0]   com_q;
  logic [MW-1:0]                   mass_total_q;
  logic                            valid_q;
  logic                            error_q;
  logic                            busy_q;

  logic        [NW-1:0]            node_idx;
  logic        [MW-1:0]            mass_add;
  logic        [ACC_W-1:0]         divisor;
  logic signed [PW-1:0]            prod     [DIMS];
  logic signed [ACC_W-1:0]         sum_add  [DIMS];
  logic        [ACC_W:0]           rem_sh   [DIMS];
  logic        [ACC_W:0]           diff     [DIMS];
  logic        [DIMS-1:0]          ge;
  logic        [ACC_W-1:0]         rem_step [DIMS];
  logic        [ACC_W-1:0]         quo_step [DIMS];
  logic        [DIMS*POSITION_SIZE-1:0] com_res;

  assign node_idx = cnt_q[NW-1:0];
  assign divisor  = {{(ACC_W-MW){1'b0}}, mass_sum_q};

  always_comb begin
    mass_add = mass_sum_q + MW'(mass_q[node_idx]);
    com_res  = '0;
    ge       = '0;
    for (int d = 0; d < DIMS; d++) begin
      // Mass is unsigned: prepend a zero so the signed multiply treats it as positive.
      prod[d]    = PW'(pos_q[d][node_idx]) * PW'($signed({1'b0, mass_q[node_idx]}));
      sum_add[d] = sum_q[d] + ACC_W'(prod[d]);
      // Restoring step: the dividend lives in quo_q and is shifted out MSB first while
      // quotient bits are shifted in at the bottom.
      rem_sh[d]   = {rem_q[d], quo_q[d][ACC_W-1]};
      diff[d]     = rem_sh[d] - {1'b0, divisor};
      ge[d]       = ~diff[d][ACC_W];
      rem_step[d] = ge[d] ? diff[d][ACC_W-1:0] : rem_sh[d][ACC_W-1:0];
      quo_step[d] = {quo_q[d][ACC_W-2:0], ge[d]};
      // Only the low bits survive truncation, so negate just those.
      com_res[d*POSITION_SIZE +: POSITION_SIZE] = neg_q[d] ? -quo_step[d][POSITION_SIZE-1:0]
                                                           :  quo_step[d][POSITION_SIZE-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      mass_sum_q   <= '0;
      neg_q        <= '0;
      com_q        <= '0;
      mass_total_q <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++) mass_q[n] <= '0;
      for (int d = 0; d < DIMS; d++) begin
        sum_q[d] <= '0;
        rem_q[d] <= '0;
        quo_q[d] <= '0;
        for (int n = 0; n < NUM_NODES; n++) pos_q[d][n] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_in) begin
            for (int n = 0; n < NUM_NODES; n++) begin
              mass_q[n] <= masses_in[n*MASS_SIZE +: MASS_SIZE];
              for (int d = 0; d < DIMS; d++)
                pos_q[d][n] <= nodes_in[(d*NUM_NODES+n)*POSITION_SIZE +: POSITION_SIZE];
            end
            for (int d = 0; d < DIMS; d++) sum_q[d] <= '0;
            mass_sum_q <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_TALLY;
          end
        end
        S_TALLY: begin
          if (cnt_q != CW'(NUM_NODES)) begin
            for (int d = 0; d < DIMS; d++) sum_q[d] <= sum_add[d];
            mass_sum_q <= mass_add;
            cnt_q      <= cnt_q + CW'(1);
          end else if (mass_sum_q == '0) begin
            // Zero total mass: no division, flag the result and publish zeros.
            com_q        <= '0;
            mass_total_q <= '0;
            valid_q      <= 1'b1;
            error_q      <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            for (int d = 0; d < DIMS; d++) begin
              neg_q[d] <= sum_q[d][ACC_W-1];
              quo_q[d] <= sum_q[d][ACC_W-1] ? ACC_W'(-sum_q[d]) : ACC_W'(sum_q[d]);
              rem_q[d] <= '0;
            end
            bit_q   <= '0;
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          for (int d = 0; d < DIMS; d++) begin
            rem_q[d] <= rem_step[d];
            quo_q[d] <= quo_step[d];
          end
          bit_q <= bit_q + BW'(1);
          if (bit_q == BW'(ACC_W-1)) begin
            com_q        <= com_res;
            mass_total_q <= mass_sum_q;
            valid_q      <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign com_out        = com_q;
  assign mass_total_out = mass_total_q;
  assign valid_out      = valid_q;
  assign error_out      = error_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_weighted_center_of_mass.sv
// tb/tb_weighted_center_of_mass.sv - self-checking bench for weighted_center_of_mass
module tb_weighted_center_of_mass;

  localparam int P     = 11;
  localparam int M     = 8;
  localparam int N     = 16;
  localparam int D     = 2;
  localparam int MT    = M + 4;
  localparam int ACC_W = P + M + 4;
  localparam int LAT   = N + ACC_W + 1;
  localparam int LAT_Z = N + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vin = 1'b0;
  logic [D*N*P-1:0] nodes = '0;
  logic [N*M-1:0]   masses = '0;
  logic [D*P-1:0]   com;
  logic [MT-1:0]    mt;
  logic             vout, err, busy;

  weighted_center_of_mass #(
    .POSITION_SIZE(P), .MASS_SIZE(M), .NUM_NODES(N), .DIMS(D)
  ) dut (
    .clk_in(clk), .rst_in(rst), .valid_in(vin),
    .nodes_in(nodes), .masses_in(masses),
    .com_out(com), .mass_total_out(mt),
    .valid_out(vout), .error_out(err), .busy_out(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [D*N*P-1:0] nodes;
    logic [N*M-1:0]   masses;
    int x; int y; int mt; int err;
  } vec_t;

  typedef struct { int x; int y; int mt; int err; } exp_t;

  exp_t exp_q[$];
  vec_t tbl[11];
  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  logic [D*N*P-1:0] nv;
  logic [N*M-1:0]   mv;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic set_node(input int n, input int x, input int y, input int m);
    nv[(0*N+n)*P +: P] = P'(x);
    nv[(1*N+n)*P +: P] = P'(y);
    mv[n*M +: M]       = M'(m);
  endtask

  function automatic exp_t model(input logic [D*N*P-1:0] nd, input logic [N*M-1:0] ms);
    exp_t e;
    int s [D];
    int msum;
    logic signed [P-1:0] t;
    msum = 0;
    for (int d = 0; d < D; d++) s[d] = 0;
    for (int n = 0; n < N; n++) begin
      msum += int'(ms[n*M +: M]);
      for (int d = 0; d < D; d++)
        s[d] += int'($signed(nd[(d*N+n)*P +: P])) * int'(ms[n*M +: M]);
    end
    if (msum == 0) begin
      e = '{0, 0, 0, 1};
    end else begin
      t = P'(s[0] / msum); e.x = int'(t);
      t = P'(s[1] / msum); e.y = int'(t);
      e.mt = msum; e.err = 0;
    end
    return e;
  endfunction

  // Scoreboard: every result pulse is checked against the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (vout) begin
      exp_t e;
      logic signed [P-1:0] cx, cy;
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        cx = com[P-1:0];
        cy = com[2*P-1:P];
        chk("com_x", int'(cx), e.x);
        chk("com_y", int'(cy), e.y);
        chk("mass_total", int'(mt), e.mt);
        chk("error", int'(err), e.err);
      end
    end
  end

  task automatic run_req(input logic [D*N*P-1:0] nd, input logic [N*M-1:0] ms,
                         input exp_t e, input int lat);
    int c;
    bit seen;
    @(negedge clk);
    nodes = nd; masses = ms; vin = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    vin = 1'b0;
    seen = 0; c = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (vout) begin seen = 1; c = i; break; end
    end
    chk("latency", seen ? c : -1, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int pulses, c;
    bit seen, busy_ok;

    // 0: unit masses, x=n, y=-5
    nv = '0; mv = '0;
    for (int n = 0; n < N; n++) set_node(n, n, -5, 1);
    tbl[0] = '{nv, mv, 7, -5, 16, 0};
    // 1: truncation toward zero on a negative sum
    nv = '0; mv = '0;
    set_node(0, -10, 0, 3); set_node(1, 4, 0, 1);
    for (int n = 2; n < N; n++) set_node(n, 100, 100, 0);
    tbl[1] = '{nv, mv, -6, 0, 4, 0};
    // 2: all masses zero
    nv = '0; mv = '0;
    for (int n = 0; n < N; n++) set_node(n, n * 37 - 300, 200 - n, 0);
    tbl[2] = '{nv, mv, 0, 0, 0, 1};
    // 3,4: extremes
    nv = '0; mv = '0;
    for (int n = 0; n < N; n++) set_node(n, -1024, 1023, 255);
    tbl[3] = '{nv, mv, -1024, 1023, 4080, 0};
    nv = '0; mv = '0;
    for (int n = 0; n < N; n++) set_node(n, 1023, -1024, 255);
    tbl[4] = '{nv, mv, 1023, -1024, 4080, 0};
    // 5,6: single non-zero mass returns that node exactly
    nv = '0; mv = '0;
    for (int n = 0; n < N; n++) set_node(n, 50, 60, 0);
    set_node(9, -777, 333, 1);
    tbl[5] = '{nv, mv, -777, 333, 1, 0};
    nv = '0; mv = '0;
    for (int n = 0; n < N; n++) set_node(n, -900, 900, 0);
    set_node(15, 500, -3, 255);
    tbl[6] = '{nv, mv, 500, -3, 255, 0};
    // 7..10: random, expectations from the integer model
    for (int k = 7; k < 11; k++) begin
      nv = '0; mv = '0;
      for (int n = 0; n < N; n++)
        set_node(n, int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
                 (k == 10 && n % 5 != 0) ? 0 : int'($urandom_range(0, 255)));
      e = model(nv, mv);
      tbl[k] = '{nv, mv, e.x, e.y, e.mt, e.err};
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_com", int'(com), 0);
    chk("rst_mass_total", int'(mt), 0);
    chk("rst_valid", int'(vout), 0);
    chk("rst_error", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      e = '{tbl[i].x, tbl[i].y, tbl[i].mt, tbl[i].err};
      run_req(tbl[i].nodes, tbl[i].masses, e, tbl[i].err != 0 ? LAT_Z : LAT);
    end

    // Inputs churn and valid_in pulses while busy, including during DONE.
    pulses = n_valid;
    @(negedge clk);
    nodes = tbl[0].nodes; masses = tbl[0].masses; vin = 1'b1;
    exp_q.push_back('{tbl[0].x, tbl[0].y, tbl[0].mt, tbl[0].err});
    @(posedge clk); #1;
    busy_ok = 1; seen = 0; c = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      for (int n = 0; n < N; n++) begin
        nodes[(0*N+n)*P +: P] = P'($urandom);
        nodes[(1*N+n)*P +: P] = P'($urandom);
        masses[n*M +: M] = M'($urandom);
      end
      vin = 1'b1;
      @(posedge clk); #1;
      if (!busy) busy_ok = 0;
      if (vout) begin seen = 1; c = i; break; end
    end
    chk("busy_latency", seen ? c : -1, LAT);
    chk("busy_held", int'(busy_ok), 1);
    @(negedge clk); vin = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); vin = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("busy_idle_after", int'(busy), 0);
    chk("busy_pulses", n_valid - pulses, 1);

    // Reset in the middle of TALLY aborts without a result.
    @(negedge clk);
    nodes = tbl[1].nodes; masses = tbl[1].masses; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_com", int'(com), 0);
    chk("abort_mass_total", int'(mt), 0);
    chk("abort_valid", int'(vout), 0);
    chk("abort_error", int'(err), 0);
    chk("abort_busy", int'(busy), 0);
    @(negedge clk); rst = 1'b0;
    pulses = n_valid;
    repeat (50) @(posedge clk);
    #1;
    chk("abort_pulses", n_valid - pulses, 0);
    e = '{tbl[0].x, tbl[0].y, tbl[0].mt, tbl[0].err};
    run_req(tbl[0].nodes, tbl[0].masses, e, LAT);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
